// File: rtl/pc_sequencer.sv
// pc_sequencer: RV32I fetch PC register and one-outstanding fetch sequencer.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of masking them.
module pc_sequencer (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        misalign_trap,
  output logic [31:0] trap_epc
);
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;
  state_t state;
  logic accept;
  assign imem_req_valid = (state == RUN) & ~stall;
  assign accept = imem_req_valid & imem_req_ready;
  assign imem_addr = pc_out;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;
  logic bad_target;
  assign bad_target = (state == RUN) & redirect_valid & (|redirect_target[1:0]);
  always_ff @(posedge clk)
    if (!rst) begin
      state <= BOOT;
      pc_out <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_pc <= '0;
      misalign_trap <= 1'b0;
      trap_epc <= '0;
    end else begin
      fetch_valid <= accept & ~redirect_valid;
      if (accept) fetch_pc <= pc_out;
      misalign_trap <= bad_target;
      if (bad_target) trap_epc <= redirect_target;
      if (state == BOOT) state <= RUN;
      else if (state == TRAP) begin
        state <= RUN;
        pc_out <= TRAP_VECTOR;
      end else if (bad_target) state <= TRAP;
      else if (redirect_valid) pc_out <= redirect_target;
      else if (accept) pc_out <= pc_plus4;
    end
`else
  assign misalign_trap = 1'b0;
  assign trap_epc = '0;
  always_ff @(posedge clk)
    if (!rst) begin
      state <= BOOT;
      pc_out <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      fetch_pc <= '0;
    end else begin
      fetch_valid <= accept & ~redirect_valid;
      if (accept) fetch_pc <= pc_out;
      if (state == BOOT) state <= RUN;
      else if (redirect_valid) pc_out <= redirect_target & ~32'h3;
      else if (accept) pc_out <= pc_plus4;
    end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus randomized stimulus checked every cycle against a behavioural model.
module tb_pc_sequencer;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, redirect_valid = 1'b0, imem_req_ready = 1'b0;
  logic [31:0] redirect_target = '0, pc_plus4;
  logic [31:0] pc_out, imem_addr, fetch_pc, trap_epc;
  logic imem_req_valid, fetch_valid, misalign_trap;
  int total = 0, bad = 0;
  bit m_known = 1'b0;
  int m_mode = 0;
  logic [31:0] m_pc = '0, m_fpc = '0, m_epc = '0;
  logic m_fv = 1'b0, m_mt = 1'b0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .pc_plus4(pc_plus4), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .misalign_trap(misalign_trap), .trap_epc(trap_epc)
  );

  always #5 clk = ~clk;
  assign pc_plus4 = pc_out + 32'd4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Mode: 0 boot, 1 run, 2 trap. One call = one clock cycle with the given inputs.
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rt, input logic rdy);
    logic req, acc;
    int n_mode;
    logic [31:0] n_pc, n_fpc, n_epc;
    logic n_fv, n_mt;
    rst = r; stall = s; redirect_valid = rv; redirect_target = rt; imem_req_ready = rdy;
    #1;
    req = (m_mode == 1) && !s;
    if (m_known) begin
      chk("pc_out", pc_out, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("req_valid", {31'd0, imem_req_valid}, {31'd0, req});
      chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
      chk("fetch_pc", fetch_pc, m_fpc);
      chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_mt});
      chk("trap_epc", trap_epc, m_epc);
    end
    acc = req && rdy;
    n_mode = m_mode; n_pc = m_pc; n_fpc = m_fpc; n_epc = m_epc;
    n_fv = acc && !rv;
    n_mt = 1'b0;
    if (acc) n_fpc = m_pc;
    if (!r) begin
      n_mode = 0; n_pc = 32'h0; n_fv = 1'b0; n_fpc = 32'h0; n_epc = 32'h0;
    end else if (m_mode == 0) n_mode = 1;
    else if (m_mode == 2) begin
      n_mode = 1; n_pc = 32'h100;
    end else if (rv) begin
      if (TEN && (rt % 4 != 0)) begin
        n_mode = 2; n_mt = 1'b1; n_epc = rt;
      end else n_pc = rt - (rt % 4);
    end else if (acc) n_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
    if (!r) m_known = 1'b1;
    m_mode = n_mode; m_pc = n_pc; m_fv = n_fv; m_fpc = n_fpc; m_mt = n_mt; m_epc = n_epc;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("lit reset pc", pc_out, 32'h0);
    chk("lit reset fv", {31'd0, fetch_valid}, 32'h0);
    step(1, 0, 0, 0, 1);
    chk("lit boot pc", pc_out, 32'h0);
    step(1, 0, 0, 0, 1);
    chk("lit pc4", pc_out, 32'h4);
    chk("lit fpc0", fetch_pc, 32'h0);
    chk("lit fv0", {31'd0, fetch_valid}, 32'h1);
    step(1, 0, 0, 0, 1);
    chk("lit pc8", pc_out, 32'h8);
    chk("lit fpc4", fetch_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      chk("lit wait pc", pc_out, 32'h8);
      chk("lit wait req", {31'd0, imem_req_valid}, 32'h1);
    end
    chk("lit wait fv", {31'd0, fetch_valid}, 32'h0);
    step(1, 0, 0, 0, 1);
    chk("lit pcC", pc_out, 32'hC);
    chk("lit fpc8", fetch_pc, 32'h8);
    step(1, 1, 0, 0, 1);
    chk("lit stall req", {31'd0, imem_req_valid}, 32'h0);
    chk("lit stall pc", pc_out, 32'hC);
    step(1, 1, 1, 32'h40, 1);
    chk("lit stall redir", pc_out, 32'h40);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 32'h80, 1);
    chk("lit squash pc", pc_out, 32'h80);
    chk("lit squash fv", {31'd0, fetch_valid}, 32'h0);
    step(1, 0, 1, 32'h82, 1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("lit trap pulse", {31'd0, misalign_trap}, 32'h1);
    chk("lit trap epc", trap_epc, 32'h82);
    chk("lit trap req", {31'd0, imem_req_valid}, 32'h0);
    step(1, 0, 1, 32'h200, 1);
    chk("lit trap vec", pc_out, 32'h100);
    chk("lit trap end", {31'd0, misalign_trap}, 32'h0);
`else
    chk("lit mask pc", pc_out, 32'h80);
    chk("lit no trap", {31'd0, misalign_trap}, 32'h0);
`endif
    step(1, 0, 1, 32'hFFFF_FFFC, 0);
    chk("lit top pc", pc_out, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 1);
    chk("lit wrap pc", pc_out, 32'h0);
    chk("lit wrap fpc", fetch_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("lit rst pc", pc_out, 32'h0);
    chk("lit rst req", {31'd0, imem_req_valid}, 32'h0);
    chk("lit rst fv", {31'd0, fetch_valid}, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
      step($urandom_range(0, 63) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t,
           $urandom_range(0, 1) == 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
